mmio_periph: RTL

MMIO_PERIPH -- requirements
Module: mmio_periph

---
 rtl/mmio_pkg.sv | 48 ++++
 rtl/sync_fifo.sv | 51 +++++
 rtl/mmio_periph.sv | 135 +++++++++++++
 3 files changed

// File: rtl/mmio_pkg.sv
// Shared register map, field positions and the read-mux helper for the MMIO
// peripheral block.
package mmio_pkg;

    localparam logic [11:0] OFF_TXDATA = 12'h000;
    localparam logic [11:0] OFF_STATUS = 12'h004;
    localparam logic [11:0] OFF_TIME   = 12'h008;
    localparam logic [11:0] OFF_CMP    = 12'h00C;
    localparam logic [11:0] OFF_IRQ    = 12'h010;

    localparam int ST_FULL    = 0;
    localparam int ST_EMPTY   = 1;
    localparam int ST_OVF     = 2;
    localparam int ST_CNT_LSB = 8;
    localparam int ST_CNT_W   = 7;

    localparam int IRQ_PEND = 0;
    localparam int IRQ_EN   = 1;

    localparam logic [31:0] CMP_RESET = 32'hFFFF_FFFF;

    typedef struct packed {
        logic        we;
        logic [11:0] off;
        logic [31:0] data;
    } wr_req_t;

    // Shared by both read ports so they can never disagree.
    function automatic logic [31:0] reg_read(
        input logic [11:0] off,
        input logic [31:0] status,
        input logic [31:0] tm,
        input logic [31:0] cmp,
        input logic [31:0] irq
    );
        logic [31:0] rd;
        rd = 32'h0;
        case (off)
            OFF_STATUS: rd = status;
            OFF_TIME:   rd = tm;
            OFF_CMP:    rd = cmp;
            OFF_IRQ:    rd = irq;
            default:    rd = 32'h0;
        endcase
        return rd;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a separate occupancy counter; pop is ignored while
// empty and push is accepted when full only if a pop happens the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign dout  = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage is deliberately left unreset; dout is masked while empty.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/mmio_periph.sv
// 4 KB MMIO peripheral: console TX FIFO, free-running timer with compare
// interrupt, two combinational read ports and one write port.
module mmio_periph
    import mmio_pkg::*;
#(
    parameter logic [31:0] MMIO_BASE = 32'h8000_0000,
    parameter int          TXDEPTH   = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] busra1,
    output logic [31:0] busrd1,
    output logic        hit1,
    input  logic [31:0] busra2,
    output logic [31:0] busrd2,
    output logic        hit2,
    input  logic [31:0] buswa3,
    input  logic [31:0] buswd3,
    input  logic        buswe3,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        timer_irq
);

    localparam int CW = $clog2(TXDEPTH) + 1;

    wr_req_t       wr;
    logic          hit3;
    logic          wr_txdata;
    logic          wr_status;
    logic          wr_time;
    logic          wr_cmp;
    logic          wr_irq;
    logic          tx_pop;

    logic [CW-1:0] fifo_count;
    logic          fifo_full;
    logic          fifo_empty;
    logic          ovf_q;

    logic [31:0]   tm_q;
    logic [31:0]   cmp_q;
    logic          pend_q;
    logic          en_q;

    logic [31:0]   status_word;
    logic [31:0]   irq_word;

    // Byte-lane bits of every address are don't-care.
    logic          unused_addr_lsbs;
    assign unused_addr_lsbs = ^{busra1[1:0], busra2[1:0], buswa3[1:0]};

    assign hit1 = (busra1[31:12] == MMIO_BASE[31:12]);
    assign hit2 = (busra2[31:12] == MMIO_BASE[31:12]);
    assign hit3 = (buswa3[31:12] == MMIO_BASE[31:12]);

    assign wr.we   = buswe3 && hit3;
    assign wr.off  = {buswa3[11:2], 2'b00};
    assign wr.data = buswd3;

    assign wr_txdata = wr.we && (wr.off == OFF_TXDATA);
    assign wr_status = wr.we && (wr.off == OFF_STATUS);
    assign wr_time   = wr.we && (wr.off == OFF_TIME);
    assign wr_cmp    = wr.we && (wr.off == OFF_CMP);
    assign wr_irq    = wr.we && (wr.off == OFF_IRQ);

    assign tx_valid = !fifo_empty;
    assign tx_pop   = tx_valid && tx_ready;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (TXDEPTH)
    ) u_txfifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (wr_txdata),
        .din     (wr.data[7:0]),
        .pop     (tx_pop),
        .dout    (tx_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    always_comb begin
        status_word = 32'h0;
        status_word[ST_FULL]  = fifo_full;
        status_word[ST_EMPTY] = fifo_empty;
        status_word[ST_OVF]   = ovf_q;
        status_word[ST_CNT_LSB +: ST_CNT_W] = ST_CNT_W'(fifo_count);
    end

    always_comb begin
        irq_word = 32'h0;
        irq_word[IRQ_PEND] = pend_q;
        irq_word[IRQ_EN]   = en_q;
    end

    assign busrd1 = hit1 ? reg_read({busra1[11:2], 2'b00}, status_word, tm_q, cmp_q, irq_word) : 32'h0;
    assign busrd2 = hit2 ? reg_read({busra2[11:2], 2'b00}, status_word, tm_q, cmp_q, irq_word) : 32'h0;

    // A push that the FIFO cannot absorb is dropped and remembered here.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ovf_q <= 1'b0;
        end else if (wr_txdata && fifo_full && !tx_pop) begin
            ovf_q <= 1'b1;
        end else if (wr_status) begin
            ovf_q <= 1'b0;
        end
    end

    // Match uses the pre-increment TIME, and a match beats a W1C clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tm_q      <= 32'h0;
            cmp_q     <= CMP_RESET;
            pend_q    <= 1'b0;
            en_q      <= 1'b0;
            timer_irq <= 1'b0;
        end else begin
            tm_q <= wr_time ? wr.data : tm_q + 32'd1;
            if (wr_cmp) cmp_q <= wr.data;
            if (wr_irq) en_q  <= wr.data[IRQ_EN];
            if (tm_q == cmp_q) begin
                pend_q <= 1'b1;
            end else if (wr_irq && wr.data[IRQ_PEND]) begin
                pend_q <= 1'b0;
            end
            timer_irq <= pend_q && en_q;
        end
    end

endmodule
